// File: rtl/picorv32_wb_bridge.sv
// picorv32_wb_bridge
//   Converts picorv32 native memory requests that hit a configurable address
//   window into single Wishbone B4 pipelined master cycles. It completes each
//   cycle with a one-cycle o_mem_ready pulse. Bus errors complete the request
//   with ERR_RDATA and record the error code and address.
//
//   Optional feature macro: WB_BRIDGE_TIMEOUT_EN
//     When defined, the bridge forces a timeout completion (code 2'b10) after
//     TIMEOUT_CYCLES cycles in REQ+WAIT without a slave response.
//     When undefined, the bridge waits for the slave indefinitely.
//
// Ports
//   clk, i_resetn             clock, synchronous active-low reset
//   i_mem_valid/addr/wdata/wstrb   picorv32 native request (wstrb == 0 -> read)
//   o_mem_ready, o_mem_rdata  completion pulse and read data
//   o_hit                     combinational window hit (valid & address match)
//   o_wb_cyc/stb/we/addr/data/sel  Wishbone master outputs
//   i_wb_data/ack/stall/err   Wishbone slave responses
//   o_err_valid               error completion pulse (coincident with ready)
//   o_err_code, o_err_addr    last error code (01 bus, 10 timeout) and address
module picorv32_wb_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  i_resetn,
  input  logic                  i_mem_valid,
  input  logic [31:0]           i_mem_addr,
  input  logic [31:0]           i_mem_wdata,
  input  logic [3:0]            i_mem_wstrb,
  output logic                  o_mem_ready,
  output logic [31:0]           o_mem_rdata,
  output logic                  o_hit,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [31:0]           o_wb_data,
  output logic [3:0]            o_wb_sel,
  input  logic [31:0]           i_wb_data,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic                  i_wb_err,
  output logic                  o_err_valid,
  output logic [1:0]            o_err_code,
  output logic [31:0]           o_err_addr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] ERR_CODE_BUS     = 2'b01;
  localparam logic [1:0] ERR_CODE_TIMEOUT = 2'b10;

  // A TIMEOUT_CYCLES outside 1..255 cannot be represented by the 8-bit counter;
  // this block marks such a configuration in the elaborated hierarchy.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_cycles_out_of_range
  end

  state_t r_state;
  state_t w_state_next;

  logic w_hit;
  logic w_accept;
  logic w_stb_drop;
  logic w_done_ok;
  logic w_done_err;
  logic w_done_to;
  logic w_done;
  logic w_timeout;

  logic [31:0] r_req_addr;
  logic        r_mem_ready;
  logic [31:0] r_mem_rdata;
  logic        r_wb_cyc;
  logic        r_wb_stb;
  logic        r_wb_we;
  logic [31:0] r_wb_data;
  logic [3:0]  r_wb_sel;
  logic        r_err_valid;
  logic [1:0]  r_err_code;
  logic [31:0] r_err_addr;

  assign w_hit = i_mem_valid && ((i_mem_addr & ADDR_MASK) == BASE_ADDR);
  assign o_hit = w_hit;

`ifdef WB_BRIDGE_TIMEOUT_EN
  // Cycles spent in REQ+WAIT for the current request.
  logic [7:0] r_to_cnt;

  assign w_timeout = (({1'b0, r_to_cnt} + 9'd1) == 9'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!i_resetn) begin
      r_to_cnt <= 8'd0;
    end else if (w_accept) begin
      r_to_cnt <= 8'd0;
    end else if (r_state == S_REQ || r_state == S_WAIT) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and completion decode; err beats ack, ack beats timeout.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_stb_drop   = 1'b0;
    w_done_ok    = 1'b0;
    w_done_err   = 1'b0;
    w_done_to    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_accept     = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (!i_wb_stall) begin
          w_stb_drop   = 1'b1;
          w_state_next = S_WAIT;
          if (i_wb_err) begin
            w_done_err = 1'b1;
          end else if (i_wb_ack) begin
            w_done_ok = 1'b1;
          end else if (w_timeout) begin
            w_done_to = 1'b1;
          end
        end else if (w_timeout) begin
          w_done_to = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_wb_err) begin
          w_done_err = 1'b1;
        end else if (i_wb_ack) begin
          w_done_ok = 1'b1;
        end else if (w_timeout) begin
          w_done_to = 1'b1;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (w_done_ok || w_done_err || w_done_to) begin
      w_state_next = S_RESP;
    end
  end

  assign w_done = w_done_ok || w_done_err || w_done_to;

  // Registered bus, response and error outputs.
  always_ff @(posedge clk) begin
    if (!i_resetn) begin
      r_req_addr  <= 32'd0;
      r_mem_ready <= 1'b0;
      r_mem_rdata <= 32'd0;
      r_wb_cyc    <= 1'b0;
      r_wb_stb    <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_data   <= 32'd0;
      r_wb_sel    <= 4'd0;
      r_err_valid <= 1'b0;
      r_err_code  <= 2'd0;
      r_err_addr  <= 32'd0;
    end else begin
      r_mem_ready <= w_done;
      r_err_valid <= w_done_err || w_done_to;
      if (w_accept) begin
        r_req_addr <= i_mem_addr;
        r_wb_data  <= i_mem_wdata;
        r_wb_we    <= |i_mem_wstrb;
        r_wb_sel   <= (|i_mem_wstrb) ? i_mem_wstrb : 4'hF;
        r_wb_cyc   <= 1'b1;
        r_wb_stb   <= 1'b1;
      end
      if (w_stb_drop) begin
        r_wb_stb <= 1'b0;
      end
      if (w_done) begin
        r_wb_cyc <= 1'b0;
        r_wb_stb <= 1'b0;
      end
      if (w_done_ok) begin
        r_mem_rdata <= r_wb_we ? 32'd0 : i_wb_data;
      end
      if (w_done_err || w_done_to) begin
        r_mem_rdata <= ERR_RDATA;
        r_err_code  <= w_done_to ? ERR_CODE_TIMEOUT : ERR_CODE_BUS;
        r_err_addr  <= r_req_addr;
      end
    end
  end

  assign o_mem_ready = r_mem_ready;
  assign o_mem_rdata = r_mem_rdata;
  assign o_wb_cyc    = r_wb_cyc;
  assign o_wb_stb    = r_wb_stb;
  assign o_wb_we     = r_wb_we;
  assign o_wb_addr   = r_req_addr[ADDR_WIDTH-1:0];
  assign o_wb_data   = r_wb_data;
  assign o_wb_sel    = r_wb_sel;
  assign o_err_valid = r_err_valid;
  assign o_err_code  = r_err_code;
  assign o_err_addr  = r_err_addr;

endmodule

// File: doc/picorv32_wb_bridge.md
# picorv32_wb_bridge

Parametrised bridge that converts picorv32 native memory requests falling inside a configurable address window into single Wishbone B4 pipelined master cycles and returns a `mem_ready` handshake to the core. It sits beside the on-chip SRAM, UART and timer slaves in the SoC top and replaces ad-hoc per-peripheral Wishbone glue. It adds stall handling, bus-error completion, error address capture and an optional timeout so an unresponsive slave can never hang the CPU.

## Interface
- `ADDR_WIDTH`, 32: width of `o_wb_addr`; the low `ADDR_WIDTH` bits of the captured request address.
- `BASE_ADDR`, 32'h8000_0000: window base; hit when `(i_mem_addr & ADDR_MASK) == BASE_ADDR`.
- `ADDR_MASK`, 32'hFFFF_0000: window mask.
- `TIMEOUT_CYCLES`, 255: cycles in REQ+WAIT before forced termination (8-bit counter, range 1-255).
- `ERR_RDATA`, 32'hDEAD_BEEF: read data returned on error or timeout.
- `clk` in 1: clock.
- `i_resetn` in 1: synchronous, active-low reset.
- `i_mem_valid` in 1: core request valid.
- `i_mem_addr` in 32: core address.
- `i_mem_wdata` in 32: core write data.
- `i_mem_wstrb` in 4: byte strobes; 0 means read.
- `o_mem_ready` out 1: one-cycle completion pulse.
- `o_mem_rdata` out 32: read data, valid while `o_mem_ready` is high.
- `o_hit` out 1: combinational window hit (`i_mem_valid` AND window match), for the top-level ready/rdata mux.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each: Wishbone master controls.
- `o_wb_addr` out ADDR_WIDTH: Wishbone address.
- `o_wb_data` out 32: Wishbone write data.
- `o_wb_sel` out 4: Wishbone byte select.
- `i_wb_data` in 32: slave read data.
- `i_wb_ack`, `i_wb_stall`, `i_wb_err` in 1 each: slave responses.
- `o_err_valid` out 1: one-cycle pulse, coincident with `o_mem_ready`, on an error completion.
- `o_err_code` out 2: 2'b01 bus error, 2'b10 timeout; held until the next error.
- `o_err_addr` out 32: full core address of the last errored request; held until the next error.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: on `o_hit`, register address, data and `we = |i_mem_wstrb`. Set `sel = wstrb` for writes, 4'hF for reads. Assert `cyc` and `stb`, then go to REQ.
- REQ: hold `stb` while `i_wb_stall` is high. On `!i_wb_stall`, drop `stb` and go to WAIT. If `i_wb_ack` or `i_wb_err` also arrives in that cycle, go directly to RESP.
- WAIT: `cyc` stays high and `stb` stays low. On `i_wb_err`, go to RESP as an error completion. On `i_wb_ack`, go to RESP and register `i_wb_data` into `o_mem_rdata` (reads only; writes return 0).
- RESP: `o_mem_ready` = 1 for exactly one cycle and `cyc` = 0. Go to IDLE; a hit in the following IDLE cycle is treated as a new request.
- Error completion: `o_mem_rdata` = ERR_RDATA, `o_err_valid` pulses, `o_err_code` and `o_err_addr` are updated.
- Priority within a cycle: err over ack; ack over timeout.
- Responses outside REQ/WAIT are ignored.
- If `i_mem_valid` drops mid-transaction, the bus cycle still completes and `o_mem_ready` still pulses.

## Timing
- Reset (`i_resetn` = 0 at a posedge): state IDLE, counter 0, and every registered output cleared to 0, including `o_wb_cyc`, `o_wb_stb`, `o_mem_ready`, `o_err_*` and all data/address outputs.
- Reset mid-transaction aborts the cycle; `cyc` and `stb` are low on the next cycle.
- Minimum latency, zero-stall slave acking one cycle after acceptance: `i_mem_valid` at cycle 0, `stb` at 1, `ack` at 2, `o_mem_ready` at 3.
- Each stall cycle adds one cycle of latency.
- At most one outstanding Wishbone transaction; `cyc` is never asserted in IDLE or RESP.
- All outputs are registered except `o_hit`.

## Configuration
- `WB_BRIDGE_TIMEOUT_EN` defined: an 8-bit counter clears on entry to REQ and increments every REQ/WAIT cycle. When it reaches TIMEOUT_CYCLES with no ack or err, `cyc` and `stb` drop and the bridge goes to RESP with code 2'b10.
- `WB_BRIDGE_TIMEOUT_EN` undefined: no counter; the bridge waits indefinitely and code 2'b10 is never produced.

## Test plan
- Read of 0x8000_0004, slave acks next cycle with 0x0000_002A: `o_wb_sel` = 4'hF, `we` = 0, `o_mem_ready` at cycle 3, `o_mem_rdata` = 0x2A.
- Write of 0x1234_5678 with wstrb 4'b0011, slave stalls 3 cycles: `stb` is held 4 cycles, `o_wb_sel` = 4'b0011, data is stable throughout, `o_mem_ready` at cycle 6.
- Read with `i_wb_err` in WAIT: `o_mem_rdata` = 0xDEAD_BEEF, `o_err_valid` pulses, `o_err_code` = 01, `o_err_addr` = request address.
- `WB_BRIDGE_TIMEOUT_EN` with TIMEOUT_CYCLES = 10 and a silent slave: `cyc` drops after 10 cycles, `o_err_code` = 10, `o_mem_ready` pulses.
- Access to 0x0000_1000: `o_hit` = 0, no `cyc`, no `o_mem_ready`. Same-cycle ack+err: error completion.
- `i_resetn` low while in WAIT: the next cycle has all outputs 0 and state IDLE. A following request completes normally.
